// File: rtl/next_in_if.sv
// Board-input bundle between the raw push-button/switch pins and the conditioned strobe/data
// seen by the downstream accumulator FSM.
interface next_in_if #(
  parameter int PCOUNT_W = 8
);
  // Handshake: there is no valid/ready back-pressure. next_pulse is a one-cycle strobe that the
  // consumer must take in the cycle it is high. in_sampled is valid with that strobe and holds
  // until the next strobe.
  logic                next_raw;
  logic                in_raw;
  logic                next_pulse;
  logic                in_sampled;
  logic                in_level;
  logic                next_level;
  logic [PCOUNT_W-1:0] press_count;

  modport master (
    output next_raw,
    output in_raw,
    input  next_pulse,
    input  in_sampled,
    input  in_level,
    input  next_level,
    input  press_count
  );

  modport slave (
    input  next_raw,
    input  in_raw,
    output next_pulse,
    output in_sampled,
    output in_level,
    output next_level,
    output press_count
  );
endinterface

// File: rtl/next_in_conditioner.sv
// Synchronises and debounces the next push-button and in switch, then emits a press strobe,
// the data bit captured at that press, and a wrapping press counter.
module next_in_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int PCOUNT_W        = 8
) (
  input logic      clk,
  input logic      reset,
  next_in_if.slave bus
);
  localparam int                   CH_NEXT = 0;
  localparam int                   CH_IN   = 1;
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]             raw;
  logic [SYNC_STAGES-1:0] sync_chain [2];
  logic [CNT_W-1:0]       cnt [2];
  logic [1:0]             stable;
  logic                   stable_next_d;
  logic                   rise;
  logic                   next_pulse_q;
  logic                   in_sampled_q;
  logic [PCOUNT_W-1:0]    press_count_q;

  assign raw[CH_NEXT] = bus.next_raw;
  assign raw[CH_IN]   = bus.in_raw;
  assign rise         = stable[CH_NEXT] & ~stable_next_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        sync_chain[c] <= '0;
        cnt[c]        <= '0;
      end
      stable        <= '0;
      stable_next_d <= 1'b0;
      next_pulse_q  <= 1'b0;
      in_sampled_q  <= 1'b0;
      press_count_q <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        sync_chain[c] <= {sync_chain[c][SYNC_STAGES-2:0], raw[c]};
        // Any return to the stable level before commit throws away the partial count.
        if (sync_chain[c][SYNC_STAGES-1] == stable[c]) begin
          cnt[c] <= '0;
        end else if (cnt[c] == CNT_MAX) begin
          stable[c] <= sync_chain[c][SYNC_STAGES-1];
          cnt[c]    <= '0;
        end else begin
          cnt[c] <= cnt[c] + 1'b1;
        end
      end
      stable_next_d <= stable[CH_NEXT];
      next_pulse_q  <= rise;
      // stable[CH_IN] here is the pre-commit value if in settles on this same edge.
      if (rise) begin
        in_sampled_q  <= stable[CH_IN];
        press_count_q <= press_count_q + 1'b1;
      end
    end
  end

  assign bus.next_pulse  = next_pulse_q;
  assign bus.in_sampled  = in_sampled_q;
  assign bus.in_level    = stable[CH_IN];
  assign bus.next_level  = stable[CH_NEXT];
  assign bus.press_count = press_count_q;
endmodule

// File: tb/tb_next_in_conditioner.sv
// Bench for next_in_conditioner: directed press scenarios plus a randomized run compared
// against a run-length behavioural model of the debounce/press rules.
module tb_next_in_conditioner;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int PW   = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  next_in_if #(.PCOUNT_W(PW)) bus ();

  next_in_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (16),
    .PCOUNT_W       (PW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Raw samples travel through a SYNC-deep history; a level is accepted once it has disagreed
  // with the accepted level for DEB consecutive edges.
  logic hist_n[$];
  logic hist_i[$];
  int   run_n = 0, run_i = 0;
  logic m_st_n = 1'b0, m_st_i = 1'b0, m_st_n_prev = 1'b0;
  logic m_pulse = 1'b0, m_samp = 1'b0;
  int   m_count = 0;

  task automatic settle(input logic s, inout logic st, inout int run);
    if (s != st) begin
      run++;
      if (run == DEB) begin
        st  = s;
        run = 0;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic model_step();
    logic s_n, s_i;
    if (reset) begin
      hist_n.delete();
      hist_i.delete();
      for (int i = 0; i < SYNC; i++) begin
        hist_n.push_back(1'b0);
        hist_i.push_back(1'b0);
      end
      run_n = 0; run_i = 0;
      m_st_n = 1'b0; m_st_i = 1'b0; m_st_n_prev = 1'b0;
      m_pulse = 1'b0; m_samp = 1'b0; m_count = 0;
    end else begin
      s_n = hist_n[SYNC-1];
      s_i = hist_i[SYNC-1];
      m_pulse = m_st_n && !m_st_n_prev;
      if (m_pulse) begin
        m_samp  = m_st_i;
        m_count = (m_count + 1) % (1 << PW);
      end
      m_st_n_prev = m_st_n;
      settle(s_n, m_st_n, run_n);
      settle(s_i, m_st_i, run_i);
      hist_n.push_front(bus.next_raw);
      void'(hist_n.pop_back());
      hist_i.push_front(bus.in_raw);
      void'(hist_i.pop_back());
    end
  endtask

  // One clock: model advances on the active edge, caller observes/drives at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic press(input int hold, input int gap, output int pulses);
    pulses = 0;
    bus.next_raw = 1'b1;
    repeat (hold) begin
      cycle();
      if (bus.next_pulse === 1'b1) pulses++;
    end
    bus.next_raw = 1'b0;
    repeat (gap) begin
      cycle();
      if (bus.next_pulse === 1'b1) pulses++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin
      bus.next_raw = 1'($urandom_range(0, 1));
      bus.in_raw   = 1'($urandom_range(0, 1));
      cycle();
      n_checks++; if (bus.next_pulse !== 1'b0) $display("FAIL reset_next_pulse got %b want 0", bus.next_pulse); else n_pass++;
      n_checks++; if (bus.in_sampled !== 1'b0) $display("FAIL reset_in_sampled got %b want 0", bus.in_sampled); else n_pass++;
      n_checks++; if (bus.in_level !== 1'b0) $display("FAIL reset_in_level got %b want 0", bus.in_level); else n_pass++;
      n_checks++; if (bus.next_level !== 1'b0) $display("FAIL reset_next_level got %b want 0", bus.next_level); else n_pass++;
      n_checks++; if (bus.press_count !== 8'd0) $display("FAIL reset_press_count got %0d want 0", bus.press_count); else n_pass++;
    end
    reset = 1'b0;
    bus.next_raw = 1'b0;
    bus.in_raw   = 1'b0;
    repeat (10) cycle();
  endtask

  task automatic test_clean_press();
    int start;
    start = m_count;
    bus.next_raw = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      n_checks++;
      if (bus.next_pulse !== (k == 6))
        $display("FAIL clean_press_pulse edge %0d got %b want %b", k, bus.next_pulse, (k == 6));
      else n_pass++;
    end
    n_checks++;
    if (bus.press_count !== PW'(start + 1)) $display("FAIL clean_press_count got %0d want %0d", bus.press_count, PW'(start + 1));
    else n_pass++;
    bus.next_raw = 1'b0;
    repeat (10) cycle();
  endtask

  task automatic test_glitch();
    int start;
    start = m_count;
    for (int k = 0; k < 15; k++) begin
      bus.next_raw = (k < 3);
      cycle();
      n_checks++; if (bus.next_pulse !== 1'b0) $display("FAIL glitch_pulse edge %0d got %b want 0", k, bus.next_pulse); else n_pass++;
      n_checks++; if (bus.next_level !== 1'b0) $display("FAIL glitch_level edge %0d got %b want 0", k, bus.next_level); else n_pass++;
    end
    n_checks++;
    if (bus.press_count !== PW'(start)) $display("FAIL glitch_count got %0d want %0d", bus.press_count, PW'(start));
    else n_pass++;
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    int start;
    pat = 5'b10101;
    start = m_count;
    for (int k = 0; k < 20; k++) begin
      bus.next_raw = (k < 5) ? pat[k] : 1'b1;
      cycle();
      n_checks++;
      if (bus.next_pulse !== (k == 10))
        $display("FAIL bounce_pulse edge %0d got %b want %b", k, bus.next_pulse, (k == 10));
      else n_pass++;
    end
    n_checks++;
    if (bus.press_count !== PW'(start + 1)) $display("FAIL bounce_count got %0d want %0d", bus.press_count, PW'(start + 1));
    else n_pass++;
    bus.next_raw = 1'b0;
    repeat (10) cycle();
  endtask

  task automatic test_data_capture();
    logic want;
    int   seen;
    for (int p = 0; p < 2; p++) begin
      want = (p == 0);
      bus.in_raw = want;
      repeat (10) cycle();
      if (p == 1) begin
        n_checks++;
        if (bus.in_sampled !== 1'b1) $display("FAIL capture_hold got %b want 1", bus.in_sampled); else n_pass++;
        n_checks++;
        if (bus.in_level !== 1'b0) $display("FAIL capture_level got %b want 0", bus.in_level); else n_pass++;
      end
      seen = 0;
      bus.next_raw = 1'b1;
      repeat (12) begin
        cycle();
        if (bus.next_pulse === 1'b1) begin
          seen++;
          n_checks++;
          if (bus.in_sampled !== want) $display("FAIL capture_data press %0d got %b want %b", p, bus.in_sampled, want);
          else n_pass++;
        end
      end
      n_checks++;
      if (seen != 1) $display("FAIL capture_pulses press %0d got %0d want 1", p, seen); else n_pass++;
      bus.next_raw = 1'b0;
      repeat (10) cycle();
    end
  endtask

  task automatic test_wrap();
    int p, total;
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    total = 0;
    repeat (256) begin
      press(8, 8, p);
      total += p;
    end
    n_checks++; if (total != 256) $display("FAIL wrap_pulses got %0d want 256", total); else n_pass++;
    n_checks++; if (bus.press_count !== 8'd0) $display("FAIL wrap_zero got %0d want 0", bus.press_count); else n_pass++;
    press(8, 8, p);
    n_checks++; if (bus.press_count !== 8'd1) $display("FAIL wrap_one got %0d want 1", bus.press_count); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int p;
    bus.in_raw = 1'b1;
    repeat (10) cycle();
    press(8, 8, p);
    bus.next_raw = 1'b1;
    repeat (2) cycle();
    reset = 1'b1;
    cycle();
    n_checks++; if (bus.next_pulse !== 1'b0) $display("FAIL midrst_next_pulse got %b want 0", bus.next_pulse); else n_pass++;
    n_checks++; if (bus.in_sampled !== 1'b0) $display("FAIL midrst_in_sampled got %b want 0", bus.in_sampled); else n_pass++;
    n_checks++; if (bus.in_level !== 1'b0) $display("FAIL midrst_in_level got %b want 0", bus.in_level); else n_pass++;
    n_checks++; if (bus.next_level !== 1'b0) $display("FAIL midrst_next_level got %b want 0", bus.next_level); else n_pass++;
    n_checks++; if (bus.press_count !== 8'd0) $display("FAIL midrst_press_count got %0d want 0", bus.press_count); else n_pass++;
    cycle();
    reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      cycle();
      n_checks++;
      if (bus.next_pulse !== (k == 6))
        $display("FAIL midrst_pulse edge %0d got %b want %b", k, bus.next_pulse, (k == 6));
      else n_pass++;
    end
    n_checks++; if (bus.press_count !== 8'd1) $display("FAIL midrst_count got %0d want 1", bus.press_count); else n_pass++;
    bus.next_raw = 1'b0;
    repeat (10) cycle();
  endtask

  task automatic test_random();
    int hold_n, hold_i;
    hold_n = 0;
    hold_i = 0;
    for (int k = 0; k < 800; k++) begin
      if (hold_n == 0) begin bus.next_raw = ~bus.next_raw; hold_n = $urandom_range(1, 10); end
      if (hold_i == 0) begin bus.in_raw = ~bus.in_raw; hold_i = $urandom_range(1, 10); end
      hold_n--;
      hold_i--;
      reset = ($urandom_range(0, 199) == 0);
      cycle();
      n_checks++; if (bus.next_pulse !== m_pulse) $display("FAIL rand_next_pulse cyc %0d got %b want %b", k, bus.next_pulse, m_pulse); else n_pass++;
      n_checks++; if (bus.in_sampled !== m_samp) $display("FAIL rand_in_sampled cyc %0d got %b want %b", k, bus.in_sampled, m_samp); else n_pass++;
      n_checks++; if (bus.in_level !== m_st_i) $display("FAIL rand_in_level cyc %0d got %b want %b", k, bus.in_level, m_st_i); else n_pass++;
      n_checks++; if (bus.next_level !== m_st_n) $display("FAIL rand_next_level cyc %0d got %b want %b", k, bus.next_level, m_st_n); else n_pass++;
      n_checks++; if (bus.press_count !== PW'(m_count)) $display("FAIL rand_press_count cyc %0d got %0d want %0d", k, bus.press_count, m_count); else n_pass++;
    end
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.next_raw = 1'b0;
    bus.in_raw   = 1'b0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_data_capture();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
